// File: rtl/acc_stream_arbiter.sv
// acc_stream_arbiter
//   Shares one accelerator unit between NUM_REQ requester streams. A grant
//   covers a whole batch: NUM_IN words from the winner into the unit, then
//   NUM_OUT result words from the unit back to that same requester. Batches
//   are atomic, and winners are picked round-robin.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_data/req_ready  per-requester input streams (data packed,
//                                 requester i at [i*DATA_W +: DATA_W])
//   rsp_valid/rsp_ready         per-requester result handshake
//   rsp_data                    shared result word, qualify with rsp_valid
//   acc_in_*                    to the unit's consumer port
//   acc_out_*                   from the unit's producer port
//   grant_id                    requester owning the unit
//   busy                        high while a batch is in progress
//   batch_done                  one-cycle pulse after the last result word
module acc_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_IN  = 64,
    parameter int NUM_OUT = 64,
    parameter int DATA_W  = 64,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      acc_in_valid,
    output logic [DATA_W-1:0]         acc_in_data,
    input  logic                      acc_in_ready,
    input  logic                      acc_out_valid,
    input  logic [DATA_W-1:0]         acc_out_data,
    output logic                      acc_out_ready,
    output logic [GW-1:0]             grant_id,
    output logic                      busy,
    output logic                      batch_done
);

    localparam int CW = $clog2((NUM_IN > NUM_OUT) ? NUM_IN : NUM_OUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

    state_t                          state;
    logic [CW-1:0]                   in_cnt;
    logic [CW-1:0]                   out_cnt;
    logic [GW-1:0]                   last_grant;
    logic [GW-1:0]                   winner;
    logic [NUM_REQ-1:0][DATA_W-1:0]  req_word;

    assign req_word = req_data;

    // Round-robin pick: scan from the far end back toward last_grant+1 so the
    // nearest valid requester after last_grant is the one left standing.
    always_comb begin
        logic [GW-1:0] cand;
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) winner = cand;
        end
    end

    // Datapath steering: only the granted requester sees the unit, and only
    // the port belonging to the current phase is opened.
    always_comb begin
        acc_in_valid  = 1'b0;
        acc_in_data   = '0;
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_data      = '0;
        acc_out_ready = 1'b0;
        case (state)
            S_FEED: begin
                acc_in_valid        = req_valid[grant_id];
                acc_in_data         = req_word[grant_id];
                req_ready[grant_id] = acc_in_ready;
            end
            S_DRAIN: begin
                rsp_valid[grant_id] = acc_out_valid;
                rsp_data            = acc_out_data;
                acc_out_ready       = rsp_ready[grant_id];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_cnt     <= '0;
            out_cnt    <= '0;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            busy       <= 1'b0;
            batch_done <= 1'b0;
        end else begin
            batch_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        grant_id <= winner;
                        in_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (acc_in_valid && acc_in_ready) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == CW'(NUM_IN - 1)) begin
                            out_cnt <= '0;
                            state   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (acc_out_valid && acc_out_ready) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt == CW'(NUM_OUT - 1)) begin
                            batch_done <= 1'b1;
                            last_grant <= grant_id;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_stream_arbiter.sv
// Bench for acc_stream_arbiter: an echo unit (result = input + 1) plus
// per-requester source queues; a scoreboard queue holds expected results.
module tb_acc_stream_arbiter;

    localparam int NR = 4;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [NR-1:0]     rsp_ready;
    logic              acc_in_valid;
    logic [DW-1:0]     acc_in_data;
    logic              acc_in_ready;
    logic              acc_out_valid;
    logic [DW-1:0]     acc_out_data;
    logic              acc_out_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic              batch_done;

    acc_stream_arbiter #(.NUM_REQ(NR), .NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .acc_in_valid(acc_in_valid), .acc_in_data(acc_in_data), .acc_in_ready(acc_in_ready),
        .acc_out_valid(acc_out_valid), .acc_out_data(acc_out_data), .acc_out_ready(acc_out_ready),
        .grant_id(grant_id), .busy(busy), .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] mask;        // requesters offering data
        int            stall_after; // drop granted valid for 5 cycles after this many words (0 = never)
        bit            keep;        // keep requests up through batch end (back-to-back)
        bit            toggle;      // toggle rsp_ready every cycle
        logic [1:0]    exp_g;       // expected winner
    } vec_t;

    vec_t vt1[8];
    vec_t vt2[8];

    logic [DW-1:0] src_q[NR][$];
    logic [DW-1:0] unit_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] data_ctr = 16'h0010;
    logic [NR-1:0] rv_en = '0;
    logic [1:0]    cur_g = '0;
    bit            stall = 0;
    bit            tog_mode = 0;
    bit            phase = 0;
    bit            prev_keep = 0;
    int            n_in = 0;
    int            n_out = 0;
    int            done_cnt = 0;
    int            pass_cnt = 0;
    int            tot_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        tot_cnt++;
        $display("FAIL %s: got no event, expected one within bound (t=%0t)", name, $time);
    endtask

    task automatic refill(input logic [NR-1:0] mask);
        for (int r = 0; r < NR; r++)
            if (mask[r])
                while (src_q[r].size() < 2 * NI) begin
                    src_q[r].push_back(data_ctr);
                    data_ctr = data_ctr + 1'b1;
                end
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            req_valid[r] = rv_en[r] && (src_q[r].size() > 0) && !(stall && r == int'(cur_g));
            req_data[r*DW +: DW] = (src_q[r].size() > 0) ? src_q[r][0] : '0;
        end
        acc_in_ready  = 1'b1;
        acc_out_valid = unit_q.size() > 0;
        acc_out_data  = (unit_q.size() > 0) ? unit_q[0] : '0;
        phase         = ~phase;
        rsp_ready     = (tog_mode && !phase) ? '0 : '1;
    endtask

    task automatic sample();
        int            pre_in;
        logic [NR-1:0] g_mask;
        logic [DW-1:0] w;
        pre_in = n_in;
        g_mask = '0;
        g_mask[cur_g] = 1'b1;
        if (!busy) begin
            chk("idle_quiet", {req_ready, rsp_valid, acc_in_valid, acc_out_ready, rsp_data}, '0);
        end else if (pre_in < NI) begin
            chk("feed_grant", grant_id, cur_g);
            chk("feed_hold", {acc_out_ready, rsp_valid}, '0);
            chk("feed_ready", req_ready, acc_in_ready ? g_mask : '0);
            if (acc_in_valid && acc_in_ready) begin
                if (src_q[cur_g].size() == 0) fail("feed_src_word");
                else begin
                    w = src_q[cur_g].pop_front();
                    chk("acc_in_data", acc_in_data, w);
                    unit_q.push_back(w + 1'b1);
                    exp_q.push_back(w + 1'b1);
                end
                n_in++;
            end
        end else begin
            chk("drain_grant", grant_id, cur_g);
            chk("drain_in_quiet", {acc_in_valid, req_ready}, '0);
            chk("out_ready_follow", acc_out_ready, rsp_ready[cur_g]);
            chk("rsp_valid_route", rsp_valid, acc_out_valid ? g_mask : '0);
            if (acc_out_valid && acc_out_ready) void'(unit_q.pop_front());
            if (rsp_valid[cur_g] && rsp_ready[cur_g]) begin
                if (exp_q.size() == 0) fail("rsp_expected_word");
                else begin
                    w = exp_q.pop_front();
                    chk("rsp_data", rsp_data, w);
                end
                n_out++;
            end
        end
        if (batch_done) begin
            done_cnt++;
            chk("busy_falls", busy, 0);
            chk("done_words", {n_in, n_out}, {NI, NO});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        sample();
    endtask

    task automatic run_batch(input vec_t v);
        int w;
        bit got;
        bit stalled;
        rv_en    = v.mask;
        refill(v.mask);
        cur_g    = v.exp_g;
        tog_mode = v.toggle;
        n_in     = 0;
        n_out    = 0;
        stalled  = 0;
        w = 0; got = 0;
        while (!got && w < 20) begin
            tick();
            w++;
            if (busy) got = 1;
        end
        if (!got) begin
            fail("grant_timeout");
            return;
        end
        chk("rr_grant", grant_id, v.exp_g);
        if (prev_keep) chk("idle_gap", w, 1);
        w = 0; got = 0;
        while (!got && w < 200) begin
            if (v.stall_after > 0 && !stalled && n_in == v.stall_after) begin
                stall = 1;
                repeat (5) begin
                    tick();
                    chk("stall_grant", grant_id, cur_g);
                    chk("stall_no_hs", acc_in_valid && acc_in_ready, 0);
                end
                stall   = 0;
                stalled = 1;
            end
            if (!v.keep && n_in == NI) rv_en = '0;
            tick();
            w++;
            if (batch_done) got = 1;
        end
        if (!got) fail("batch_timeout");
        prev_keep = v.keep;
    endtask

    initial begin
        int w;
        vt1[0] = '{4'b0100, 0, 1'b0, 1'b0, 2'd2};
        vt1[1] = '{4'b0001, 0, 1'b1, 1'b0, 2'd0};
        vt1[2] = '{4'b0001, 0, 1'b0, 1'b0, 2'd0};
        vt1[3] = '{4'b1011, 2, 1'b0, 1'b0, 2'd1};
        vt1[4] = '{4'b0001, 0, 1'b0, 1'b1, 2'd0};
        vt1[5] = '{4'b1010, 0, 1'b0, 1'b0, 2'd1};
        vt1[6] = '{4'b1010, 0, 1'b0, 1'b0, 2'd3};
        vt1[7] = '{4'b0110, 0, 1'b0, 1'b0, 2'd1};
        for (int i = 0; i < 8; i++)
            vt2[i] = '{4'b1111, 0, (i != 7), 1'b0, 2'(i % 4)};

        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        rsp_ready     = '0;
        acc_in_ready  = 1'b0;
        acc_out_valid = 1'b0;
        acc_out_data  = '0;
        #2;
        chk("reset_state", {grant_id, busy, batch_done, req_ready, rsp_valid,
                            acc_in_valid, acc_out_ready, rsp_data}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_batch(vt1[i]);

        // Reset in the middle of a feed; requester 2 would win next otherwise.
        rv_en = 4'b1111;
        refill(4'b1111);
        cur_g = 2'd2;
        n_in  = 0;
        n_out = 0;
        w = 0;
        while (n_in < 2 && w < 30) begin
            tick();
            w++;
        end
        if (n_in < 2) fail("reset_prep");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", {grant_id, busy, batch_done, req_ready, rsp_valid,
                                acc_in_valid, acc_out_ready, rsp_data}, '0);
        unit_q.delete();
        exp_q.delete();
        prev_keep = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_batch(vt2[i]);

        chk("done_count", done_cnt, 16);
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/acc_stream_arbiter.md
Name: acc_stream_arbiter

Overview:
- Shares one accelerator unit between NUM_REQ requester streams.
- Each grant is a whole batch: NUM_IN input words go from the granted requester into the unit's consumer port. NUM_OUT result words from the unit's producer port then go back to that same requester.
- Batches are atomic and never interleaved. Requesters are served in round-robin order.
- Sits between the FIFO controller's per-requester queues and a single acc_unit instance.

Parameters:
- NUM_REQ, 4, number of requester streams (>=1).
- NUM_IN, 64, words consumed by the unit per batch (>=1).
- NUM_OUT, 64, words produced by the unit per batch (>=1).
- DATA_W, 64, word width.
- GW (localparam), max(1, clog2(NUM_REQ)), width of the grant ID.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester input valid.
- req_data  in  NUM_REQ*DATA_W  per-requester input word; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester input ready.
- rsp_valid  out  NUM_REQ  per-requester result valid.
- rsp_data  out  DATA_W  result word, shared by all requesters; qualify with rsp_valid.
- rsp_ready  in  NUM_REQ  per-requester result ready.
- acc_in_valid  out  1  to unit consumer port, valid.
- acc_in_data  out  DATA_W  to unit consumer port, data.
- acc_in_ready  in  1  from unit consumer port, ready.
- acc_out_valid  in  1  from unit producer port, valid.
- acc_out_data  in  DATA_W  from unit producer port, data.
- acc_out_ready  out  1  to unit producer port, ready.
- grant_id  out  GW  requester currently owning the unit.
- busy  out  1  high in any state other than S_IDLE.
- batch_done  out  1  one-cycle pulse when a batch completes.

Behaviour:
- Reset values:
  - state = S_IDLE; in_cnt = out_cnt = 0; grant_id = 0; last_grant = NUM_REQ-1, so requester 0 has first priority.
  - All valid/ready outputs 0; busy = 0; batch_done = 0; rsp_data = 0.
- FSM states: S_IDLE, S_FEED, S_DRAIN.
- S_IDLE:
  - If any req_valid is high, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register the winner into grant_id, clear in_cnt, go to S_FEED.
  - Arbitration costs exactly 1 cycle. No handshakes occur in S_IDLE.
- S_FEED:
  - acc_in_valid = req_valid[grant_id]; acc_in_data = req_data[grant_id]; req_ready[grant_id] = acc_in_ready.
  - All other req_ready = 0. acc_out_ready = 0, so early unit output is held.
  - Each acc_in handshake increments in_cnt.
  - On the handshake where in_cnt == NUM_IN-1: clear out_cnt and go to S_DRAIN.
- S_DRAIN:
  - rsp_valid[grant_id] = acc_out_valid; rsp_data = acc_out_data; acc_out_ready = rsp_ready[grant_id].
  - All other rsp_valid = 0. acc_in_valid = 0. All req_ready = 0.
  - Each handshake increments out_cnt.
  - On the handshake where out_cnt == NUM_OUT-1: pulse batch_done the next cycle, set last_grant = grant_id, go to S_IDLE.
- rsp_data is 0 outside S_DRAIN.
- Counters are clog2(max(NUM_IN,NUM_OUT))+1 bits. They never wrap mid-batch and are cleared on state entry.
- Boundary conditions:
  - Granted requester drops req_valid mid-batch: stall in S_FEED indefinitely; no re-arbitration and no preemption.
  - Granted requester deasserts rsp_ready: stall in S_DRAIN; acc_out_ready follows it combinationally.
  - All requesters valid every cycle: strict rotation 0,1,2,3,0,...
  - Single requester valid: it wins every batch. Back-to-back batches cost 1 idle cycle between them.
  - NUM_REQ = 1: grant_id is always 0.
  - Reset mid-batch: immediate return to reset values. Unit state is the unit's own concern.

Test Plan:
- Requester 2 only, NUM_IN=NUM_OUT=4, data 0x10..0x13, unit echoes data+1 → grant_id=2; acc_in sees 0x10..0x13; rsp_valid[2] delivers 0x11..0x14; batch_done pulses once; busy falls the same cycle.
- All 4 requesters valid continuously for 8 batches → grant order 0,1,2,3,0,1,2,3; exactly 1 S_IDLE cycle between batches.
- Requester 1 granted, req_valid[1] low for 5 cycles after word 2 while req_valid[0] and req_valid[3] are high → no handshake and grant_id stays 1; the batch resumes and completes intact.
- acc_out_valid asserted during S_FEED → acc_out_ready=0 and no rsp_valid until S_DRAIN; result count is exactly NUM_OUT.
- rsp_ready[0] toggling 1,0,1,0 in S_DRAIN → acc_out_ready mirrors it; words delivered in order with no loss or duplication.
- rst_n asserted after 2 of 4 input words → all outputs return to reset values asynchronously; after release, requester 0 wins first when all are valid.
